// File: rtl/rv32_pkg.sv
// Shared RV32 front-end definitions: fetch FSM state encoding, the canonical
// NOP instruction word and the default reset PC.
package rv32_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit.
//
// The unit issues one request at a time, waits for the response, and then
// holds the instruction for the decoder until it is accepted. A redirect can
// arrive in any state; when a request is still outstanding, the FSM passes
// through FLUSH so that the stale response is swallowed.
//
// Handshakes:
//   imem_req/imem_valid - imem_req is a one-cycle pulse; memory returns
//     exactly one imem_valid pulse per request, at least one cycle later.
//   inst_valid/dec_ready - an instruction transfers on a cycle where
//     inst_valid && dec_ready; inst_out/pc_out stay stable until then.
//
// Build option: IFU_MISALIGN_CHK_EN
//   defined   - a fetch from a PC with pc[1:0] != 0 issues no request and
//               presents a NOP with fetch_fault set.
//   undefined - redirect targets are word-aligned when loaded, so fetch_fault
//               never asserts.
//
// dbg_state exposes the FSM state for checkers.
module instruction_fetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  input  logic        dec_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault,
  output logic [1:0]  dbg_state
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  inst_q, pc_q;
  logic         fault_q;
  logic         cap_mem, cap_nop;
  logic         misaligned;
  logic [31:0]  target;

`ifdef IFU_MISALIGN_CHK_EN
  assign misaligned = (pc[1:0] != 2'b00);
  assign target     = redirect_pc;
`else
  assign misaligned = 1'b0;
  assign target     = redirect_pc & 32'hFFFF_FFFC;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // PC register and the instruction/PC/fault capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      inst_q  <= '0;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (cap_mem) begin
        inst_q  <= imem_rdata;
        pc_q    <= pc;
        fault_q <= 1'b0;
      end else if (cap_nop) begin
        inst_q  <= NOP_INST;
        pc_q    <= pc;
        fault_q <= 1'b1;
      end
    end
  end

  // Next-state, next-PC and capture decisions; redirect always takes priority.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cap_mem   = 1'b0;
    cap_nop   = 1'b0;
    case (state)
      FETCH: begin
        if (redirect) begin
          pc_nxt = target;
          // No request goes out for a misaligned PC, so nothing is in flight.
          state_nxt = misaligned ? FETCH : FLUSH;
        end else if (misaligned) begin
          cap_nop   = 1'b1;
          state_nxt = HOLD;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_nxt = target;
          // Response arriving with the redirect is dropped and the request
          // is closed; otherwise it is still in flight and must be flushed.
          state_nxt = imem_valid ? FETCH : FLUSH;
        end else if (imem_valid) begin
          cap_mem   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nxt    = target;
          state_nxt = FETCH;
        end else if (dec_ready) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = FETCH;
        end
      end
      FLUSH: begin
        if (redirect) pc_nxt = target;
        if (imem_valid) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Moore outputs decoded from the state; reset masks the strobes.
  always_comb begin
    imem_req    = (state == FETCH) && !rst && !misaligned;
    imem_addr   = pc;
    inst_valid  = (state == HOLD) && !rst;
    inst_out    = inst_q;
    pc_out      = pc_q;
    fetch_fault = fault_q && inst_valid;
    dbg_state   = state;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural instruction memory
// of programmable latency. Memory word at address a is a + 32'h1234_0000.
module tb_instruction_fetch;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic        dec_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
  logic [1:0]  dbg_state;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .inst_out   (inst_out),
    .pc_out     (pc_out),
    .inst_valid (inst_valid),
    .dec_ready  (dec_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault),
    .dbg_state  (dbg_state)
  );

  // Clock and global watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat     = 1;
  int          pend_cnt = 0;
  logic        pend     = 1'b0;
  logic [31:0] pend_addr = '0;

  logic        s_req, s_ival, s_fault;
  logic [31:0] s_addr, s_inst, s_pc;
  logic [1:0]  s_state;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h1234_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample outputs at the negedge, then after the posedge update
  // the memory model (response pulse after lat cycles).
  task automatic cycle();
    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_ival  = inst_valid;
    s_inst  = inst_out;
    s_pc    = pc_out;
    s_fault = fetch_fault;
    s_state = dbg_state;
    if (imem_req) begin
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_addr = imem_addr;
    end
    @(posedge clk);
    #1;
    imem_valid = 1'b0;
    imem_rdata = '0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = mem_word(pend_addr);
        pend       = 1'b0;
      end
    end
  endtask

  task automatic wait_req(input string tag);
    bit found = 1'b0;
    int i = 0;
    while (!found && i < 20) begin
      cycle();
      i++;
      if (s_req) found = 1'b1;
    end
    if (!found) check({tag, "_req_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_ival(input string tag);
    bit found = 1'b0;
    int i = 0;
    while (!found && i < 20) begin
      cycle();
      i++;
      if (s_ival) found = 1'b1;
    end
    if (!found) check({tag, "_ival_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    dec_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_valid  = 1'b0;
    imem_rdata  = '0;

    // Reset values.
    repeat (3) cycle();
    check("rst_req",   {31'd0, s_req},   32'd0);
    check("rst_ival",  {31'd0, s_ival},  32'd0);
    check("rst_inst",  s_inst,           32'd0);
    check("rst_pc",    s_pc,             32'd0);
    check("rst_fault", {31'd0, s_fault}, 32'd0);
    check("rst_state", {30'd0, s_state}, 32'd0);

    // Streaming with a 1-cycle memory: requests 0,4,8 in cycles 0,3,6 and
    // inst_valid in cycles 2,5,8.
    dec_ready = 1'b1;
    rst       = 1'b0;
    for (int c = 0; c < 9; c++) begin
      cycle();
      check($sformatf("stream_req_c%0d", c),  {31'd0, s_req},  {31'd0, (c % 3) == 0});
      check($sformatf("stream_ival_c%0d", c), {31'd0, s_ival}, {31'd0, (c % 3) == 2});
      if ((c % 3) == 0)
        check($sformatf("stream_addr_c%0d", c), s_addr, 32'(4 * (c / 3)));
      if ((c % 3) == 2) begin
        check($sformatf("stream_inst_c%0d", c), s_inst, mem_word(32'(4 * (c / 3))));
        check($sformatf("stream_pc_c%0d", c),   s_pc,   32'(4 * (c / 3)));
      end
    end

    // Decoder stall: instruction held stable, no new request.
    dec_ready = 1'b0;
    wait_req("stall");
    check("stall_addr", s_addr, 32'h0000_000C);
    wait_ival("stall");
    for (int i = 0; i < 5; i++) begin
      cycle();
      check($sformatf("stall_ival_%0d", i), {31'd0, s_ival}, 32'd1);
      check($sformatf("stall_req_%0d", i),  {31'd0, s_req},  32'd0);
      check($sformatf("stall_inst_%0d", i), s_inst, mem_word(32'h0000_000C));
      check($sformatf("stall_pc_%0d", i),   s_pc,   32'h0000_000C);
    end
    lat       = 3;
    dec_ready = 1'b1;
    cycle();
    check("stall_accept_ival", {31'd0, s_ival}, 32'd1);
    dec_ready = 1'b0;
    cycle();
    check("stall_next_req",  {31'd0, s_req}, 32'd1);
    check("stall_next_addr", s_addr, 32'h0000_0010);

    // Redirect while WAIT with a 3-cycle memory: stale response is flushed.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    cycle();
    redirect = 1'b0;
    check("wait_redir_ival", {31'd0, s_ival}, 32'd0);
    check("wait_redir_req",  {31'd0, s_req},  32'd0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      check($sformatf("flush_ival_%0d", i), {31'd0, s_ival}, 32'd0);
      check($sformatf("flush_req_%0d", i),  {31'd0, s_req},  32'd0);
    end
    cycle();
    check("flush_next_req",  {31'd0, s_req}, 32'd1);
    check("flush_next_addr", s_addr, 32'h0000_0100);
    wait_ival("redir");
    check("redir_pc",   s_pc,   32'h0000_0100);
    check("redir_inst", s_inst, mem_word(32'h0000_0100));

    // Redirect and dec_ready together in HOLD: redirect wins.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    dec_ready   = 1'b1;
    cycle();
    check("hold_both_ival", {31'd0, s_ival}, 32'd1);
    redirect  = 1'b0;
    dec_ready = 1'b0;
    cycle();
    check("hold_both_req",  {31'd0, s_req}, 32'd1);
    check("hold_both_addr", s_addr, 32'h0000_0200);
    wait_ival("hold_both");
    check("hold_both_pc", s_pc, 32'h0000_0200);

    // PC wrap from 32'hFFFFFFFC to 0.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    cycle();
    check("wrap_top_addr", s_addr, 32'hFFFF_FFFC);
    wait_ival("wrap_top");
    check("wrap_top_pc",   s_pc,   32'hFFFF_FFFC);
    check("wrap_top_inst", s_inst, mem_word(32'hFFFF_FFFC));
    dec_ready = 1'b1;
    cycle();
    dec_ready = 1'b0;
    cycle();
    check("wrap_req",  {31'd0, s_req}, 32'd1);
    check("wrap_addr", s_addr, 32'h0000_0000);
    wait_ival("wrap");
    check("wrap_pc", s_pc, 32'h0000_0000);

    // Misaligned redirect target.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    cycle();
    redirect = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    cycle();
    check("mis_no_req", {31'd0, s_req}, 32'd0);
    cycle();
    check("mis_ival",  {31'd0, s_ival},  32'd1);
    check("mis_fault", {31'd0, s_fault}, 32'd1);
    check("mis_inst",  s_inst, NOP_INST);
    check("mis_pc",    s_pc,   32'h0000_0102);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    cycle();
    redirect = 1'b0;
    wait_ival("mis_recover");
    check("mis_recover_pc",    s_pc, 32'h0000_0300);
    check("mis_recover_fault", {31'd0, s_fault}, 32'd0);
`else
    cycle();
    check("mis_req",  {31'd0, s_req}, 32'd1);
    check("mis_addr", s_addr, 32'h0000_0100);
    wait_ival("mis");
    check("mis_pc",    s_pc, 32'h0000_0100);
    check("mis_fault", {31'd0, s_fault}, 32'd0);
`endif

    // Reset mid-transaction; the stale response lands in the first FETCH
    // cycle after release and must be ignored.
    dec_ready = 1'b1;
    cycle();
    dec_ready = 1'b0;
    cycle();
    check("mid_rst_pre_req", {31'd0, s_req}, 32'd1);
    rst = 1'b1;
    cycle();
    check("mid_rst_req", {31'd0, s_req}, 32'd0);
    cycle();
    check("mid_rst_inst", s_inst, 32'd0);
    check("mid_rst_pc",   s_pc,   32'd0);
    rst = 1'b0;
    cycle();
    check("post_rst_req",  {31'd0, s_req}, 32'd1);
    check("post_rst_addr", s_addr, 32'h0000_0000);
    for (int i = 0; i < 2; i++) begin
      cycle();
      check($sformatf("post_rst_ival_%0d", i), {31'd0, s_ival}, 32'd0);
    end
    wait_ival("post_rst");
    check("post_rst_pc",   s_pc,   32'h0000_0000);
    check("post_rst_inst", s_inst, mem_word(32'h0000_0000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
